register_pipe: RTL and testbench
================================

REGISTER_PIPE -- requirements
Module: register_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 5, bit width of the data path; legal range 1..64.
REQ-002 SHALL have parameter DEPTH, default 2, number of register stages; legal range 1..16.
REQ-003 SHALL have port CLK  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port RESETN  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port I  input  WIDTH  upstream data.
REQ-006 SHALL have port I_VALID  input  1  upstream data valid.
REQ-007 SHALL have port I_READY  output  1  block accepts I this cycle.
REQ-008 SHALL have port O  output  WIDTH  data from the last stage.
REQ-009 SHALL have port O_VALID  output  1  last stage holds valid data.
REQ-010 SHALL have port O_READY  input  1  downstream accepts O this cycle.
REQ-011 SHALL have port COUNT  output  clog2(DEPTH+1)  number of occupied stages; present only with REGISTER_PIPE_COUNT_EN.

Function
REQ-012 SHALL hold, in each stage k (0..DEPTH-1), a WIDTH-bit data register and a valid bit v[k].
REQ-013 SHALL compute the stage ready rdy[k] = !v[k] | rdy[k+1], with rdy[DEPTH] = O_READY; combinational chain, bubble-collapsing.
REQ-014 SHALL drive I_READY = rdy[0].
REQ-015 SHALL load stage 0 with I and set v[0] when I_VALID & rdy[0]; SHALL clear v[0] when rdy[0] & !I_VALID.
REQ-016 SHALL move stage k-1 into stage k when v[k-1] & rdy[k]; SHALL clear v[k] when rdy[k] & !v[k-1].
REQ-017 SHALL hold a stage's data and valid bit unchanged while the stage is not ready (valid and next stage stalled).
REQ-018 SHALL drive O from the last stage's data register and O_VALID = v[DEPTH-1].
REQ-019 SHALL have a latency of exactly DEPTH cycles: a word accepted on edge t, into an empty pipe, is presented with O_VALID=1 after edge t+DEPTH-1.
REQ-020 SHALL sustain one transfer per cycle when O_READY is held high, with no bubbles at the output.
REQ-021 SHALL preserve order; no word is dropped or duplicated under any I_VALID/O_READY pattern.
REQ-022 SHALL, when full (all v=1) with O_READY=1 and I_VALID=1, retire the last stage, shift all stages and accept I in the same cycle.
REQ-023 SHALL, when full with O_READY=0, drive I_READY=0 and hold all stage contents.
REQ-024 SHALL keep O stable while O_VALID=1 and O_READY=0.
REQ-025 SHALL not use O_VALID or any other output to form I_READY other than through REQ-013.

Reset
REQ-026 SHALL, while RESETN=0, asynchronously clear all valid bits and data registers to 0: O=0, O_VALID=0, COUNT=0, I_READY=1.
REQ-027 SHALL discard all in-flight words on a reset assertion mid-operation; the first word accepted after release observes REQ-019 latency.

Configuration
REQ-028 SHALL, with REGISTER_PIPE_COUNT_EN defined, provide COUNT = popcount(v), updated one cycle after each transfer with the new stage contents.
REQ-029 SHALL, without REGISTER_PIPE_COUNT_EN, omit the COUNT port and all its logic; all other behaviour identical.

Structure
REQ-030 SHALL place the WIDTH/DEPTH defaults, their legal limits and the COUNT-width function in the shared package register_pipe_pkg.
REQ-031 SHALL implement one stage as sub-module register_pipe_stage (data register, valid bit, ready term), instantiated DEPTH times.
REQ-032 SHALL flag an illegal WIDTH or DEPTH at elaboration.

Verification
REQ-033 Reset: RESETN=0 mid-stream, with pipe full -> O=0, O_VALID=0, I_READY=1, COUNT=0 immediately, without a clock edge.
REQ-034 Latency: WIDTH=5, DEPTH=2, O_READY=1; I=0x15 for one cycle -> O=0x15, O_VALID=1 exactly 2 edges later, for one cycle.
REQ-035 Throughput: stream 0..31 with I_VALID=1, O_READY=1 -> O emits 0..31 on consecutive cycles, no bubbles.
REQ-036 Backpressure: DEPTH=3, O_READY=0, offer 1,2,3,4 -> 1,2,3 accepted, I_READY=0 on 4, COUNT=3, O=1 held stable.
REQ-037 Full + pass-through: pipe full, O_READY=1 and I_VALID=1 in one cycle -> one word out, one word in, COUNT unchanged.
REQ-038 Random: random I_VALID/O_READY for 10000 cycles with a scoreboard -> in-order, lossless, duplicate-free, with the COUNT macro both on and off.

Source files
------------

// File: rtl/register_pipe_pkg.sv
// Shared parameters and helpers for register_pipe: defaults, legal limits
// and the width of the optional occupancy count.
package register_pipe_pkg;

  localparam int WIDTH_DEFAULT = 5;
  localparam int WIDTH_MIN     = 1;
  localparam int WIDTH_MAX     = 64;

  localparam int DEPTH_DEFAULT = 2;
  localparam int DEPTH_MIN     = 1;
  localparam int DEPTH_MAX     = 16;

  // Enough bits to hold every occupancy value from 0 to depth inclusive.
  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/register_pipe_stage.sv
// One register_pipe stage: a data register, its valid bit and the
// bubble-collapsing ready term handed to the previous stage.
module register_pipe_stage
  import register_pipe_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] prev_data,
  input  logic             prev_valid,
  input  logic             next_ready,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic             ready
);

  // An empty stage can always take a word, even when the downstream is stalled.
  assign ready = !valid || next_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data  <= '0;
      valid <= 1'b0;
    end else if (ready) begin
      valid <= prev_valid;
      if (prev_valid) begin
        data <= prev_data;
      end
    end
  end

endmodule

// File: rtl/register_pipe.sv
// Elastic register pipeline of DEPTH valid/ready stages.
// Define REGISTER_PIPE_COUNT_EN to add the COUNT occupancy output.
module register_pipe
  import register_pipe_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic                            CLK,
  input  logic                            RESETN,
  input  logic [WIDTH-1:0]                I,
  input  logic                            I_VALID,
  output logic                            I_READY,
  output logic [WIDTH-1:0]                O,
  output logic                            O_VALID,
`ifdef REGISTER_PIPE_COUNT_EN
  output logic [count_width(DEPTH)-1:0]   COUNT,
`endif
  input  logic                            O_READY
);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("register_pipe: WIDTH=%0d outside %0d..%0d", WIDTH, WIDTH_MIN, WIDTH_MAX);
  end
  if (DEPTH < DEPTH_MIN || DEPTH > DEPTH_MAX) begin : g_bad_depth
    $error("register_pipe: DEPTH=%0d outside %0d..%0d", DEPTH, DEPTH_MIN, DEPTH_MAX);
  end

  logic [WIDTH-1:0] stage_data [DEPTH];
  logic [DEPTH-1:0] v;
  logic [DEPTH:0]   rdy;

  assign rdy[DEPTH] = O_READY;

  // Stage 0 is fed from the upstream port, every later stage from its predecessor.
  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic [WIDTH-1:0] src_data;
    logic             src_valid;

    if (k == 0) begin : g_head
      assign src_data  = I;
      assign src_valid = I_VALID;
    end else begin : g_body
      assign src_data  = stage_data[k-1];
      assign src_valid = v[k-1];
    end

    register_pipe_stage #(
      .WIDTH(WIDTH)
    ) u_stage (
      .clk       (CLK),
      .rst_n     (RESETN),
      .prev_data (src_data),
      .prev_valid(src_valid),
      .next_ready(rdy[k+1]),
      .data      (stage_data[k]),
      .valid     (v[k]),
      .ready     (rdy[k])
    );
  end

  assign I_READY = rdy[0];
  assign O       = stage_data[DEPTH-1];
  assign O_VALID = v[DEPTH-1];

`ifdef REGISTER_PIPE_COUNT_EN
  localparam int CNT_W = count_width(DEPTH);

  always_comb begin
    COUNT = '0;
    for (int k = 0; k < DEPTH; k++) begin
      COUNT = COUNT + CNT_W'(v[k]);
    end
  end
`endif

endmodule

// File: tb/tb_register_pipe.sv
// Directed and scoreboarded checks of register_pipe at DEPTH=2 and DEPTH=3.
// Honours REGISTER_PIPE_COUNT_EN the same way the design does.
module tb_register_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [4:0] i2, o2, i3, o3;
  logic       iv2, ir2, ov2, or2;
  logic       iv3, ir3, ov3, or3;
`ifdef REGISTER_PIPE_COUNT_EN
  logic [1:0] c2, c3;
`endif

  int total = 0;
  int bad   = 0;

  register_pipe #(.WIDTH(5), .DEPTH(2)) dut2 (
    .CLK(clk), .RESETN(rst_n), .I(i2), .I_VALID(iv2), .I_READY(ir2),
    .O(o2), .O_VALID(ov2),
`ifdef REGISTER_PIPE_COUNT_EN
    .COUNT(c2),
`endif
    .O_READY(or2)
  );

  register_pipe #(.WIDTH(5), .DEPTH(3)) dut3 (
    .CLK(clk), .RESETN(rst_n), .I(i3), .I_VALID(iv3), .I_READY(ir3),
    .O(o3), .O_VALID(ov3),
`ifdef REGISTER_PIPE_COUNT_EN
    .COUNT(c3),
`endif
    .O_READY(or3)
  );

  // All stimulus changes one time unit after a rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    i2 = '0; iv2 = 1'b0; or2 = 1'b0;
    i3 = '0; iv3 = 1'b0; or3 = 1'b0;
    #12;
    total++;
    if (o2 !== 5'd0 || ov2 !== 1'b0 || ir2 !== 1'b1) begin
      bad++;
      $display("[TB] FAIL reset_d2: got O=%h O_VALID=%b I_READY=%b, want 00 0 1", o2, ov2, ir2);
    end
    total++;
    if (o3 !== 5'd0 || ov3 !== 1'b0 || ir3 !== 1'b1) begin
      bad++;
      $display("[TB] FAIL reset_d3: got O=%h O_VALID=%b I_READY=%b, want 00 0 1", o3, ov3, ir3);
    end
`ifdef REGISTER_PIPE_COUNT_EN
    total++;
    if (c2 !== 2'd0 || c3 !== 2'd0) begin
      bad++;
      $display("[TB] FAIL reset_count: got %0d/%0d, want 0/0", c2, c3);
    end
`endif
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_latency;
    i2 = 5'h15; iv2 = 1'b1; or2 = 1'b1;
    tick();
    iv2 = 1'b0; i2 = '0;
    total++;
    if (ov2 !== 1'b0) begin
      bad++;
      $display("[TB] FAIL latency_early: got O_VALID=%b, want 0", ov2);
    end
    tick();
    total++;
    if (ov2 !== 1'b1 || o2 !== 5'h15) begin
      bad++;
      $display("[TB] FAIL latency_out: got O_VALID=%b O=%h, want 1 15", ov2, o2);
    end
    tick();
    total++;
    if (ov2 !== 1'b0) begin
      bad++;
      $display("[TB] FAIL latency_once: got O_VALID=%b, want 0", ov2);
    end
  endtask

  task automatic test_throughput;
    or2 = 1'b1;
    for (int c = 0; c < 34; c++) begin
      iv2 = (c < 32);
      i2  = 5'(c);
      #1;
      total++;
      if (ir2 !== 1'b1) begin
        bad++;
        $display("[TB] FAIL stream_ready c=%0d: got %b, want 1", c, ir2);
      end
      tick();
      if (c >= 1 && c <= 32) begin
        total++;
        if (ov2 !== 1'b1 || o2 !== 5'(c - 1)) begin
          bad++;
          $display("[TB] FAIL stream_out c=%0d: got O_VALID=%b O=%h, want 1 %h", c, ov2, o2, 5'(c - 1));
        end
      end
    end
    iv2 = 1'b0;
    tick();
  endtask

  task automatic test_backpressure;
    or3 = 1'b0;
    for (int w = 1; w <= 4; w++) begin
      i3 = 5'(w); iv3 = 1'b1;
      #1;
      total++;
      if (ir3 !== (w <= 3)) begin
        bad++;
        $display("[TB] FAIL bp_ready w=%0d: got %b, want %b", w, ir3, (w <= 3));
      end
      tick();
    end
    for (int h = 0; h < 3; h++) begin
      total++;
      if (ov3 !== 1'b1 || o3 !== 5'd1 || ir3 !== 1'b0) begin
        bad++;
        $display("[TB] FAIL bp_hold h=%0d: got O_VALID=%b O=%h I_READY=%b, want 1 01 0", h, ov3, o3, ir3);
      end
`ifdef REGISTER_PIPE_COUNT_EN
      total++;
      if (c3 !== 2'd3) begin
        bad++;
        $display("[TB] FAIL bp_count: got %0d, want 3", c3);
      end
`endif
      tick();
    end
  endtask

  // Pipe is full of 1,2,3 with word 4 still offered.
  task automatic test_pass_through;
    or3 = 1'b1;
    #1;
    total++;
    if (ir3 !== 1'b1) begin
      bad++;
      $display("[TB] FAIL pass_ready: got %b, want 1", ir3);
    end
    tick();
    iv3 = 1'b0; or3 = 1'b0;
    total++;
    if (ov3 !== 1'b1 || o3 !== 5'd2) begin
      bad++;
      $display("[TB] FAIL pass_out: got O_VALID=%b O=%h, want 1 02", ov3, o3);
    end
`ifdef REGISTER_PIPE_COUNT_EN
    total++;
    if (c3 !== 2'd3) begin
      bad++;
      $display("[TB] FAIL pass_count: got %0d, want 3", c3);
    end
`endif
    tick();
    or3 = 1'b1;
    for (int w = 2; w <= 4; w++) begin
      total++;
      if (ov3 !== 1'b1 || o3 !== 5'(w)) begin
        bad++;
        $display("[TB] FAIL drain w=%0d: got O_VALID=%b O=%h, want 1 %h", w, ov3, o3, 5'(w));
      end
      tick();
    end
    total++;
    if (ov3 !== 1'b0) begin
      bad++;
      $display("[TB] FAIL drain_empty: got O_VALID=%b, want 0", ov3);
    end
  endtask

  task automatic test_reset_midstream;
    or3 = 1'b0;
    for (int w = 7; w <= 9; w++) begin
      i3 = 5'(w); iv3 = 1'b1;
      tick();
    end
    iv3 = 1'b0;
    total++;
    if (ov3 !== 1'b1 || o3 !== 5'd7 || ir3 !== 1'b0) begin
      bad++;
      $display("[TB] FAIL mid_full: got O_VALID=%b O=%h I_READY=%b, want 1 07 0", ov3, o3, ir3);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (o3 !== 5'd0 || ov3 !== 1'b0 || ir3 !== 1'b1) begin
      bad++;
      $display("[TB] FAIL mid_reset: got O=%h O_VALID=%b I_READY=%b, want 00 0 1", o3, ov3, ir3);
    end
`ifdef REGISTER_PIPE_COUNT_EN
    total++;
    if (c3 !== 2'd0) begin
      bad++;
      $display("[TB] FAIL mid_reset_count: got %0d, want 0", c3);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    i3 = 5'h0A; iv3 = 1'b1; or3 = 1'b1;
    for (int e = 0; e < 4; e++) begin
      tick();
      iv3 = 1'b0;
      total++;
      if (ov3 !== (e == 2) || (e == 2 && o3 !== 5'h0A)) begin
        bad++;
        $display("[TB] FAIL post_reset_lat e=%0d: got O_VALID=%b O=%h, want %b 0a", e, ov3, o3, (e == 2));
      end
    end
  endtask

  task automatic test_random;
    logic [4:0] q[$];
    logic [4:0] prev_o = '0;
    logic       prev_hold = 1'b0;
    logic       exp_ready;
    for (int n = 0; n < 10020; n++) begin
      if (prev_hold) begin
        total++;
        if (ov2 !== 1'b1 || o2 !== prev_o) begin
          bad++;
          $display("[TB] FAIL rand_stable n=%0d: got O_VALID=%b O=%h, want 1 %h", n, ov2, o2, prev_o);
        end
      end
`ifdef REGISTER_PIPE_COUNT_EN
      total++;
      if (c2 !== 2'(q.size())) begin
        bad++;
        $display("[TB] FAIL rand_count n=%0d: got %0d, want %0d", n, c2, q.size());
      end
`endif
      if (n < 10000) begin
        iv2 = ($urandom_range(0, 3) != 0);
        or2 = ($urandom_range(0, 1) != 0);
        i2  = 5'($urandom_range(0, 31));
      end else begin
        iv2 = 1'b0;
        or2 = 1'b1;
      end
      #1;
      exp_ready = (q.size() < 2) || or2;
      total++;
      if (ir2 !== exp_ready) begin
        bad++;
        $display("[TB] FAIL rand_ready n=%0d: got %b, want %b", n, ir2, exp_ready);
      end
      if (ov2 === 1'b1 && or2) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("[TB] FAIL rand_spurious n=%0d: got O=%h, want no word", n, o2);
        end else begin
          if (o2 !== q[0]) begin
            bad++;
            $display("[TB] FAIL rand_order n=%0d: got O=%h, want %h", n, o2, q[0]);
          end
          void'(q.pop_front());
        end
      end
      if (iv2 && exp_ready) q.push_back(i2);
      prev_hold = (ov2 === 1'b1) && !or2;
      prev_o    = o2;
      tick();
    end
    total++;
    if (q.size() != 0 || ov2 !== 1'b0) begin
      bad++;
      $display("[TB] FAIL rand_drain: got %0d words left O_VALID=%b, want 0 0", q.size(), ov2);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_throughput();
    test_backpressure();
    test_pass_through();
    test_reset_midstream();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
